// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and
// EX/MEM, MEM/WB operand forwarding onto the ALU inputs.
module id_ex_stage #(
  parameter int W   = 32,
  parameter int RW  = 5,
  parameter int SCW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [W-1:0]  id_rs_val,
  input  logic [W-1:0]  id_rt_val,
  input  logic [W-1:0]  id_imm,
  input  logic          id_alusrc,
  input  logic [1:0]    id_aluop,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_regwrite,
  input  logic          id_memtoreg,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_result,
  output logic          stall,
  output logic          ex_valid,
  output logic [1:0]    ex_aluop,
  output logic [W-1:0]  ex_a,
  output logic [W-1:0]  ex_b,
  output logic [W-1:0]  ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_regwrite,
  output logic          ex_memtoreg,
  output logic [SCW-1:0] stall_count
);

  localparam logic [SCW-1:0] SC_MAX = '1;

  logic          valid;
  logic [RW-1:0] rs, rt, rd;
  logic [W-1:0]  rs_val, rt_val, imm;
  logic          alusrc;
  logic [1:0]    aluop;
  logic          memread, memwrite;
  logic          regwrite, memtoreg;

  logic rs_ex, rs_wb, rt_ex, rt_wb;
  logic [W-1:0] rt_fwd;

  // Load in EX feeding either source in ID: hold one cycle.
  assign stall = id_valid & valid & memread
               & (rd != '0)
               & ((rd == id_rs) | (rd == id_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      rs_val   <= '0;
      rt_val   <= '0;
      imm      <= '0;
      alusrc   <= 1'b0;
      aluop    <= 2'b0;
      memread  <= 1'b0;
      memwrite <= 1'b0;
      regwrite <= 1'b0;
      memtoreg <= 1'b0;
    end else if (flush | stall) begin
      valid    <= 1'b0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      rs_val   <= '0;
      rt_val   <= '0;
      imm      <= '0;
      alusrc   <= 1'b0;
      aluop    <= 2'b0;
      memread  <= 1'b0;
      memwrite <= 1'b0;
      regwrite <= 1'b0;
      memtoreg <= 1'b0;
    end else begin
      valid    <= id_valid;
      rs       <= id_rs;
      rt       <= id_rt;
      rd       <= id_rd;
      rs_val   <= id_rs_val;
      rt_val   <= id_rt_val;
      imm      <= id_imm;
      alusrc   <= id_valid & id_alusrc;
      aluop    <= id_valid ? id_aluop : 2'b0;
      memread  <= id_valid & id_memread;
      memwrite <= id_valid & id_memwrite;
      regwrite <= id_valid & id_regwrite;
      memtoreg <= id_valid & id_memtoreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && stall_count != SC_MAX) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign rs_ex = exmem_regwrite & (exmem_rd == rs) & (rs != '0);
  assign rs_wb = memwb_regwrite & (memwb_rd == rs) & (rs != '0);
  assign rt_ex = exmem_regwrite & (exmem_rd == rt) & (rt != '0);
  assign rt_wb = memwb_regwrite & (memwb_rd == rt) & (rt != '0);

  // EX/MEM is younger than MEM/WB, so it wins.
  always_comb begin
    ex_a = rs_val;
    if (rs_wb) ex_a = memwb_result;
    if (rs_ex) ex_a = exmem_result;
  end

  always_comb begin
    rt_fwd = rt_val;
    if (rt_wb) rt_fwd = memwb_result;
    if (rt_ex) rt_fwd = exmem_result;
  end

  assign ex_store_data = rt_fwd;
  assign ex_b          = alusrc ? imm : rt_fwd;

  assign ex_valid    = valid;
  assign ex_aluop    = aluop;
  assign ex_rd       = rd;
  assign ex_memread  = memread;
  assign ex_memwrite = memwrite;
  assign ex_regwrite = regwrite;
  assign ex_memtoreg = memtoreg;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage directly upstream of the EX arithmetic unit. It registers the decoded instruction and its control bits, and resolves EX/MEM and MEM/WB forwarding onto the ALU operands. It detects load-use hazards: it stalls IF/ID and inserts one bubble into EX. It drives the ALU's ALUOp, A and B inputs plus the downstream control and store data.

Parameters:
W, 32, datapath width (operands, immediates, results)
RW, 5, register specifier width
SCW, 16, stall-counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  branch/jump squash of the instruction entering EX
id_valid  in  1  ID holds a real instruction
id_rs, id_rt, id_rd  in  RW each  source/destination specifiers (id_rd = final write register)
id_rs_val, id_rt_val  in  W each  register-file read data
id_imm  in  W  extended immediate
id_alusrc  in  1  1: B = immediate
id_aluop  in  2  ALU op (bit0: 0 add, 1 sub)
id_memread, id_memwrite, id_regwrite, id_memtoreg  in  1 each  control
exmem_regwrite  in  1  EX/MEM writes a register
exmem_rd  in  RW  EX/MEM destination
exmem_result  in  W  EX/MEM ALU result
memwb_regwrite  in  1  MEM/WB writes a register
memwb_rd  in  RW  MEM/WB destination
memwb_result  in  W  MEM/WB writeback value
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_aluop  out  2  to ALU
ex_a, ex_b  out  W each  forwarded ALU operands
ex_store_data  out  W  forwarded rt for sw
ex_rd  out  RW  registered destination
ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg  out  1 each  registered control
stall_count  out  SCW  saturating count of stall cycles

Behaviour:
- Reset (rst_n=0, async): all registered fields 0, so ex_valid=0 and all ex_* control=0. stall_count=0. Outputs hold these values until the first clk edge after release.
- Internal registers: valid, rs, rt, rd, rs_val, rt_val, imm, alusrc, aluop, memread, memwrite, regwrite, memtoreg.
- Hazard (combinational): stall = id_valid & valid & memread & (rd != 0) & ((rd == id_rs) | (rd == id_rt)). This holds even when the instruction has no real rt use; the conservative extra stall is accepted.
- Per-edge update priority:
  - flush: load a bubble (valid=0, all control=0; data fields don't-care, 0 recommended).
  - else stall: load a bubble. IF/ID holds externally, so the same ID instruction is presented again next cycle.
  - else: load all id_* fields; valid = id_valid. When id_valid=0, control fields are forced to 0.
- Flush together with stall: flush wins. stall is still asserted combinationally; the upstream flush handling decides IF/ID.
- Forwarding (combinational, applied to registered rs/rt):
  - fwd(r, v) = exmem_result if exmem_regwrite & exmem_rd == r & r != 0.
  - else memwb_result if memwb_regwrite & memwb_rd == r & r != 0.
  - else v.
  - EX/MEM has priority over MEM/WB.
- ex_a = fwd(rs, rs_val). ex_store_data = fwd(rt, rt_val). ex_b = alusrc ? imm : fwd(rt, rt_val).
- Load-use timing: lw in EX with dependent in ID gives stall for 1 cycle. The next cycle EX holds the bubble and the lw is in MEM. The cycle after, the dependent is in EX and its operand is taken from memwb_result. There is exactly 1 bubble per load-use pair.
- Register 0 is never forwarded and never causes a stall.
- stall_count increments by 1 on each edge where stall=1 and rst_n=1. It saturates at 2^SCW-1 and does not wrap.
- ex_* outputs are registered except ex_a, ex_b and ex_store_data, which are mux outputs of registered data and current forwarding inputs.

Test Plan:
- Reset mid-run: assert rst_n=0 while ex_valid=1 and stall_count=5 -> outputs immediately 0, stall_count=0. First edge after release loads the ID instruction.
- EX/MEM forward: add $3 in EX/MEM with result 0x00000010; sub $4,$3,$2 enters EX with rt_val=0x3 and stale rs_val=0xDEAD -> ex_a=0x10, ex_b=0x3, ex_aluop bit0=1.
- Double hazard priority: exmem_rd=memwb_rd=5, exmem_result=0xA, memwb_result=0xB, both regwrite=1, rs=5 -> ex_a=0xA. With rs=0 and both rd=0 -> ex_a=rs_val.
- Load-use: lw $8 in EX; add $9,$8,$1 in ID -> stall=1 for exactly one cycle. Next cycle ex_valid=0 with all control 0. Following cycle, with memwb_result=0x1234 and memwb_rd=8, ex_a=0x1234. stall_count increments by 1.
- Immediate/store path: sw $6,4($7) with alusrc=1, imm=4, $6 forwarded from MEM/WB=0x55 -> ex_b=4, ex_store_data=0x55, ex_memwrite=1.
- Flush+stall and saturation: assert flush during a load-use stall -> bubble loaded. With SCW=2, hold stall for 5 cycles -> stall_count goes 1, 2, 3, 3, 3.
